// File: rtl/vote_pkg.sv
// Shared definitions for the ballot session: FSM encoding, default timing
// parameters and the one-hot helpers used by the lock and vote stages.
package vote_pkg;

    localparam int NUM_CAND     = 4;
    localparam int IDX_W        = $clog2(NUM_CAND);

    localparam int DEF_WINDOW   = 16;
    localparam int DEF_MAX_FAIL = 3;
    localparam int DEF_LOCK_CYC = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2,
        LOCKED = 2'd3
    } state_t;

    function automatic logic is_one_hot(input logic [NUM_CAND-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] one_hot_idx(input logic [NUM_CAND-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping so a full tally never rolls back to zero.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             saturated
);

    assign saturated = (count == '1);

    // NOTE: tallies are architectural state that must read zero after reset,
    // so they are reset here rather than left to power-up contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !saturated) begin
            // NOTE: non-blocking assignment keeps every register sampling the
            // pre-edge values, independent of process ordering.
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vote_session.sv
// Code-locked single-vote ballot: a Correct code opens a timed window for one
// vote, repeated Incorrect codes lock the panel out for a fixed period.
module vote_session
    import vote_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int WINDOW   = DEF_WINDOW,
    parameter int MAX_FAIL = DEF_MAX_FAIL,
    parameter int LOCK_CYC = DEF_LOCK_CYC
) (
    input  logic                clock,
    input  logic                Reset_n,
    input  logic                Correct,
    input  logic                Incorrect,
    input  logic [3:0]          Vote,
    input  logic                Clear,
    input  logic [1:0]          Sel,
    output logic                Unlocked,
    output logic                Lockout,
    output logic                Vote_Accepted,
    output logic                Invalid,
    output logic                Timeout,
    output logic [CNT_W-1:0]    Tally,
    output logic [CNT_W+1:0]    Total
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int LOCK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    state_t             state, state_nxt;
    logic [WIN_W-1:0]   win_tmr, win_nxt;
    logic [LOCK_W-1:0]  lock_tmr, lock_nxt;
    logic [FAIL_W-1:0]  fail_cnt, fail_nxt, fail_inc;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               invalid_nxt, timeout_nxt;

    logic [CNT_W-1:0]   counts [NUM_CAND];
    logic [NUM_CAND-1:0] sat_vec;
    logic               commit, clear_ok;

    assign fail_inc = fail_cnt + 1'b1;
    assign commit   = (state == COMMIT);
    assign clear_ok = (state == IDLE) && Clear;

    // NOTE: every variable gets a default before the case so no path through
    // this block can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = IDLE;
        win_nxt     = win_tmr;
        lock_nxt    = lock_tmr;
        fail_nxt    = fail_cnt;
        idx_nxt     = idx;
        invalid_nxt = 1'b0;
        timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                // A simultaneous Correct and Incorrect counts as a failure.
                if (Incorrect) begin
                    if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                        state_nxt = LOCKED;
                        lock_nxt  = LOCK_W'(LOCK_CYC - 1);
                        fail_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                        fail_nxt  = fail_inc;
                    end
                end else if (Correct) begin
                    state_nxt = ARMED;
                    win_nxt   = WIN_W'(WINDOW - 1);
                    fail_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end

            ARMED: begin
                // An accepted vote wins over expiry on the window's last cycle.
                if (is_one_hot(Vote)) begin
                    state_nxt = COMMIT;
                    idx_nxt   = one_hot_idx(Vote);
                end else begin
                    invalid_nxt = (Vote != '0);
                    if (win_tmr == '0) begin
                        state_nxt   = IDLE;
                        timeout_nxt = 1'b1;
                    end else begin
                        state_nxt = ARMED;
                        win_nxt   = win_tmr - 1'b1;
                    end
                end
            end

            COMMIT: begin
                state_nxt = IDLE;
            end

            LOCKED: begin
                if (lock_tmr == '0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = LOCKED;
                    lock_nxt  = lock_tmr - 1'b1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            win_tmr  <= '0;
            lock_tmr <= '0;
            fail_cnt <= '0;
            idx      <= '0;
            Invalid  <= 1'b0;
            Timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            win_tmr  <= win_nxt;
            lock_tmr <= lock_nxt;
            fail_cnt <= fail_nxt;
            idx      <= idx_nxt;
            Invalid  <= invalid_nxt;
            Timeout  <= timeout_nxt;
        end
    end

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clock),
            .rst_n     (Reset_n),
            .inc       (commit && (idx == IDX_W'(g))),
            .clr       (clear_ok),
            .count     (counts[g]),
            .saturated (sat_vec[g])
        );
    end

    // Total follows only votes that actually moved a tally.
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Total <= '0;
        end else if (clear_ok) begin
            Total <= '0;
        end else if (commit && !sat_vec[idx]) begin
            Total <= Total + 1'b1;
        end
    end

    assign Unlocked      = (state == ARMED);
    assign Lockout       = (state == LOCKED);
    assign Vote_Accepted = commit;
    assign Tally         = counts[Sel];

endmodule

// File: tb/tb_vote_session.sv
// Directed and randomized checks of vote_session against a transaction-level
// model of the ballot tallies and the window/lockout timing.
module tb_vote_session;

    localparam int CNT_W    = 8;
    localparam int WINDOW   = 16;
    localparam int MAX_FAIL = 3;
    localparam int LOCK_CYC = 64;
    localparam int NC       = 4;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             correct = 1'b0;
    logic             incorrect = 1'b0;
    logic             clear = 1'b0;
    logic [3:0]       vote = '0;
    logic [1:0]       sel = '0;
    logic             unlocked, lockout, va, invalid, timeout;
    logic [CNT_W-1:0] tally;
    logic [CNT_W+1:0] total;

    int n_checks = 0;
    int n_errors = 0;
    int model_tally [NC];
    int model_total = 0;

    vote_session #(
        .CNT_W    (CNT_W),
        .WINDOW   (WINDOW),
        .MAX_FAIL (MAX_FAIL),
        .LOCK_CYC (LOCK_CYC)
    ) dut (
        .clock         (clk),
        .Reset_n       (rst_n),
        .Correct       (correct),
        .Incorrect     (incorrect),
        .Vote          (vote),
        .Clear         (clear),
        .Sel           (sel),
        .Unlocked      (unlocked),
        .Lockout       (lockout),
        .Vote_Accepted (va),
        .Invalid       (invalid),
        .Timeout       (timeout),
        .Tally         (tally),
        .Total         (total)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_vote(input int c);
        if (model_tally[c] < SAT) begin
            model_tally[c]++;
            model_total++;
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NC; i++) model_tally[i] = 0;
        model_total = 0;
    endfunction

    task automatic check_tallies(input string tag);
        for (int i = 0; i < NC; i++) begin
            sel = 2'(i);
            #1;
            check({tag, "_tally"}, 32'(tally), model_tally[i]);
        end
        check({tag, "_total"}, 32'(total), model_total);
    endtask

    // One ballot: unlock, wait d cycles, present v, then follow through to IDLE.
    task automatic session(input logic [3:0] v, input int d);
        int c;
        correct = 1'b1;
        tick();
        correct = 1'b0;
        check("ses_unlocked", 32'(unlocked), 1);
        repeat (d) tick();
        vote = v;
        tick();
        vote = '0;
        if ($countones(v) == 1) begin
            c = 0;
            for (int i = 0; i < NC; i++) if (v[i]) c = i;
            check("ses_accept", {29'd0, va, invalid, timeout}, 3'b100);
            tick();
            model_vote(c);
            check("ses_after", {30'd0, va, unlocked}, 2'b00);
            check_tallies("ses");
        end else begin
            check("ses_invalid", 32'(invalid), 32'(v != '0));
            check("ses_noaccept", 32'(va), 0);
            check("ses_last_timeout", 32'(timeout), 32'(d == WINDOW - 1));
            if (d < WINDOW - 1) begin
                repeat (WINDOW - 2 - d) tick();
                check("ses_open", {30'd0, unlocked, timeout}, 2'b10);
                tick();
                check("ses_timeout", {30'd0, unlocked, timeout}, 2'b01);
            end
            check_tallies("ses_to");
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {27'd0, unlocked, lockout, va, invalid, timeout}, 0);
        check({tag, "_total"}, 32'(total), 0);
    endtask

    initial begin
        int d;
        logic [3:0] v;
        model_clear();

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst");
        check_tallies("rst");
        tick();
        tick();
        rst_n = 1'b1;

        // Basic vote for candidate 2, button held afterwards
        correct = 1'b1;
        tick();
        correct = 1'b0;
        check("s1_unlocked", 32'(unlocked), 1);
        tick();
        vote = 4'b0100;
        tick();
        check("s1_commit", {30'd0, va, unlocked}, 2'b10);
        sel = 2'd2;
        #1;
        check("s1_tally_pre", 32'(tally), 0);
        tick();
        model_vote(2);
        check("s1_va_drop", 32'(va), 0);
        check("s1_tally", 32'(tally), 1);
        check("s1_total", 32'(total), 1);
        check("s1_locked_again", 32'(unlocked), 0);
        tick();
        check("s1_held", {30'd0, va, unlocked}, 2'b00);
        vote = '0;
        check("s1_total_held", 32'(total), model_total);

        // Window expiry
        correct = 1'b1;
        tick();
        correct = 1'b0;
        for (int i = 1; i <= WINDOW; i++) begin
            tick();
            if (i < WINDOW) check("s2_open", {30'd0, unlocked, timeout}, 2'b10);
        end
        check("s2_timeout", {30'd0, unlocked, timeout}, 2'b01);
        tick();
        check("s2_timeout_drop", 32'(timeout), 0);
        check_tallies("s2");

        // Lockout after consecutive failures
        incorrect = 1'b1;
        repeat (MAX_FAIL - 1) begin
            tick();
            check("s3_prelock", 32'(lockout), 0);
        end
        tick();
        incorrect = 1'b0;
        check("s3_lock_on", 32'(lockout), 1);
        for (int i = 1; i < LOCK_CYC; i++) begin
            if (i == 10) correct = 1'b1;
            tick();
            correct = 1'b0;
            check("s3_lock", {30'd0, lockout, unlocked}, 2'b10);
        end
        tick();
        check("s3_lock_off", {30'd0, lockout, unlocked}, 2'b00);
        incorrect = 1'b1;
        tick();
        incorrect = 1'b0;
        check("s3_failcnt_cleared", 32'(lockout), 0);

        // Multi-hot vote then a valid one
        correct = 1'b1;
        tick();
        correct = 1'b0;
        vote = 4'b0011;
        tick();
        check("s4_invalid", {29'd0, invalid, va, unlocked}, 3'b101);
        vote = 4'b0001;
        tick();
        check("s4_commit", {30'd0, invalid, va}, 2'b01);
        vote = '0;
        tick();
        model_vote(0);
        check_tallies("s4");

        // Clear while ARMED is ignored
        correct = 1'b1;
        tick();
        correct = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("s5_armed", 32'(unlocked), 1);
        check_tallies("s5_noclear");
        vote = 4'b0010;
        tick();
        vote = '0;
        tick();
        model_vote(1);
        check_tallies("s5");

        // Randomized ballots with occasional clears in IDLE
        repeat (40) begin
            if ($urandom_range(0, 4) == 0) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
                model_clear();
                check_tallies("rnd_clear");
            end
            d = int'($urandom_range(0, WINDOW - 1));
            if ($urandom_range(0, 1) == 1) v = 4'(1 << $urandom_range(0, 3));
            else v = 4'($urandom_range(0, 15));
            session(v, d);
        end

        // Saturation of candidate 1
        while (model_tally[1] < SAT) session(4'b0010, 0);
        d = model_total;
        session(4'b0010, 0);
        sel = 2'd1;
        #1;
        check("sat_tally", 32'(tally), SAT);
        check("sat_total", 32'(total), d);

        // Clear in IDLE
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        check_tallies("clr_idle");

        // Reset during COMMIT discards the vote
        session(4'b1000, 3);
        correct = 1'b1;
        tick();
        correct = 1'b0;
        vote = 4'b1000;
        tick();
        check("rc_commit", 32'(va), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rc");
        vote = '0;
        model_clear();
        check_tallies("rc");
        tick();
        rst_n = 1'b1;
        correct = 1'b1;
        tick();
        correct = 1'b0;
        check("rc_first_edge", 32'(unlocked), 1);
        repeat (WINDOW) tick();
        check("rc_expired", {30'd0, unlocked, timeout}, 2'b01);
        check_tallies("rc_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vote_session.md
VOTE_SESSION -- requirements
Module: vote_session

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning:
- CNT_W, 8, width of each candidate tally
- WINDOW, 16, cycles the ballot stays open after unlock
- MAX_FAIL, 3, consecutive Incorrect pulses that trigger lockout
- LOCK_CYC, 64, lockout duration in cycles
REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning:
- clock, in, 1, single clock; all state changes on rising edge
- Reset_n, in, 1, asynchronous, active-low reset
- Correct, in, 1, code-lock success pulse, sampled on the clock
- Incorrect, in, 1, code-lock failure pulse, sampled on the clock
- Vote, in, 4, candidate buttons, one bit per candidate
- Clear, in, 1, synchronous tally clear request
- Sel, in, 2, tally read select
- Unlocked, out, 1, ballot open
- Lockout, out, 1, lockout active
- Vote_Accepted, out, 1, one-cycle vote commit strobe
- Invalid, out, 1, one-cycle strobe for a multi-hot vote
- Timeout, out, 1, one-cycle strobe when the ballot expires
- Tally, out, CNT_W, count for candidate Sel (combinational read)
- Total, out, CNT_W+2, total accepted votes

Function
REQ-003 The block SHALL implement the FSM states IDLE, ARMED, COMMIT and LOCKED, all outputs except Tally being registered or decoded from registered state.
REQ-004 IDLE with Correct=1 and Incorrect=0 SHALL go to ARMED, load win_tmr=WINDOW-1 and clear fail_cnt.
REQ-005 In IDLE, Incorrect=1 SHALL increment fail_cnt; when fail_cnt+1==MAX_FAIL the block SHALL go to LOCKED, load lock_tmr=LOCK_CYC-1 and clear fail_cnt.
REQ-006 In IDLE, Correct and Incorrect both high in the same cycle SHALL be treated as Incorrect.
REQ-007 In ARMED, Unlocked SHALL be 1, and Correct and Incorrect SHALL be ignored.
REQ-008 In ARMED, an exactly one-hot Vote SHALL capture the candidate index and go to COMMIT at that edge.
REQ-009 In ARMED, a multi-hot Vote SHALL pulse Invalid for 1 cycle, stay in ARMED and keep decrementing win_tmr.
REQ-010 In ARMED, a non-accepted cycle with win_tmr==0 SHALL go to IDLE and pulse Timeout for 1 cycle; otherwise win_tmr SHALL decrement.
REQ-011 A one-hot Vote in the cycle where win_tmr==0 SHALL be accepted (go to COMMIT) with no Timeout.
REQ-012 COMMIT SHALL last exactly 1 cycle, with Vote_Accepted=1.
REQ-013 At the edge leaving COMMIT, tally[idx] SHALL increment unless it equals 2^CNT_W-1 (saturate); Total SHALL increment only if tally[idx] incremented; the next state SHALL be IDLE.
REQ-014 A new vote SHALL require a new Correct; a held button SHALL NOT produce a second vote.
REQ-015 In LOCKED, Lockout SHALL be 1, Correct and Incorrect SHALL be ignored, and lock_tmr SHALL decrement; lock_tmr==0 SHALL go to IDLE.
REQ-016 Clear SHALL zero all tallies and Total only in IDLE; Clear in any other state SHALL be ignored.
REQ-017 Tally SHALL equal tally[Sel] in the same cycle.
REQ-018 Latency: Correct sampled at edge k SHALL give Unlocked=1 from edge k; one-hot Vote at edge m SHALL give Vote_Accepted=1 in cycle m..m+1 and the updated Tally/Total from edge m+1.

Reset
REQ-019 Reset_n=0 SHALL asynchronously force state=IDLE, with fail_cnt, win_tmr, lock_tmr, all tallies, Total, Unlocked, Lockout, Vote_Accepted, Invalid and Timeout all 0.
REQ-020 Reset asserted in ARMED or COMMIT SHALL discard the pending vote; no tally change is permitted.
REQ-021 Leaving reset SHALL be synchronous to clock; the first transition SHALL be taken on the first rising edge with Reset_n=1.

Structure
REQ-022 The state encoding and the WINDOW, MAX_FAIL and LOCK_CYC defaults SHALL reside in a shared package, vote_pkg, which is also used by the lock stage.
REQ-023 The per-candidate saturating counters SHALL be one sub-module, sat_counter (CNT_W wide, inc and clr inputs), instantiated 4 times.
REQ-024 The implementation SHALL contain no latches and no combinational loops; the next-state logic SHALL be fully specified with a default to IDLE.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Correct pulse, then Vote=4'b0100 two cycles later -> Vote_Accepted 1 cycle; Sel=2 Tally=1; Total=1; Unlocked drops.
- Correct, then no vote for 16 cycles -> Timeout pulse on cycle 16; state IDLE; tallies unchanged.
- Three Incorrect pulses -> Lockout=1 for 64 cycles; a Correct during lockout is ignored; Lockout=0 after.
- In ARMED, Vote=4'b0011 -> Invalid pulse with no commit; then Vote=4'b0001 -> tally0=1.
- Preload tally1=255 -> another vote for candidate 1 leaves tally1=255 and Total unchanged.
- Reset_n low mid-COMMIT -> all outputs 0 immediately; tallies 0; Clear in ARMED has no effect.
